branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- IF-stage consumer of the EX-stage branch feedback interface: receives resolved branch/jump outcomes from EX and produces the next-PC prediction (`pred_dest`) that EX later checks.
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter and a jump flag per entry.
- Lookup is combinational, so IF can select the next PC in the same cycle; updates are registered.
- Also keeps resolved-branch and misprediction statistics counters.

Parameters:
BIT_W, 32, PC/data width
ENTRIES, 16, number of BTB entries; power of two, >=2
IDX_W, log2(ENTRIES), index width; index = PC[IDX_W:1] (halfword aligned, compressed ISA)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
pc_i  input  BIT_W  current fetch PC
compressed_i  input  1  fetched instruction is 16-bit
pred_dest_o  output  BIT_W  predicted next PC
pred_taken_o  output  1  prediction is taken (target used)
hit_o  output  1  valid entry with matching tag at pc_i index
fb_valid_i  input  1  EX holds a branch or jump this cycle
fb_stall_i  input  1  EX stalled; feedback must be ignored
fb_pc_i  input  BIT_W  PC of the resolved instruction
fb_taken_i  input  1  branch actually taken (1 for jumps)
fb_jump_i  input  1  resolved instruction is jal/jalr
fb_target_i  input  BIT_W  resolved target address
fb_mispred_i  input  1  EX is requesting a PC correction
flush_i  input  1  invalidate all BTB entries
branch_cnt_o  output  32  count of accepted feedback events
mispred_cnt_o  output  32  count of accepted mispredictions

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Entry fields: valid, tag = PC[BIT_W-1:IDX_W+1], target[BIT_W-1:0], ctr[1:0], jump.
- Lookup (combinational):
  - hit_o = valid[idx(pc_i)] && tag match.
  - pred_taken_o = hit_o && (jump || ctr[1]).
  - pred_dest_o = pred_taken_o ? target : pc_i + (compressed_i ? 2 : 4), computed modulo 2^BIT_W.
- Update accept: upd = fb_valid_i && !fb_stall_i && !rst. Any cycle with !upd leaves the BTB and both counters unchanged.
- On upd with a tag hit at idx(fb_pc_i):
  - jump: ctr <= 2'b11, jump <= 1, target <= fb_target_i.
  - branch taken: ctr <= sat_inc(ctr), saturating at 3; target <= fb_target_i.
  - branch not taken: ctr <= sat_dec(ctr), saturating at 0; target kept; entry stays valid.
- On upd with a miss (invalid entry or tag mismatch):
  - fb_taken_i=1: allocate and overwrite whatever was at idx. valid <= 1, tag, target <= fb_target_i, jump <= fb_jump_i, ctr <= fb_jump_i ? 2'b11 : 2'b10.
  - fb_taken_i=0: no allocation; the existing entry is untouched.
- Statistics:
  - On upd: branch_cnt_o += 1; mispred_cnt_o += fb_mispred_i.
  - Both wrap modulo 2^32.
  - fb_mispred_i is ignored when !upd.
- Lookup/update collision: if the same index is read and written in one cycle, the lookup returns the pre-update contents. There is no bypass; the new contents are visible the next cycle.
- flush_i=1: all valid <= 0 next edge. A simultaneous update is dropped. Counters are unaffected.
- Reset: rst=1 clears all valid, ctr, jump, target and tag to 0, and clears branch_cnt_o and mispred_cnt_o to 0. An update presented during reset is dropped.
  - Outputs during and after reset with no entries: hit_o=0, pred_taken_o=0, pred_dest_o = pc_i+2 or pc_i+4.
- Update latency: 1 cycle (feedback at edge N is visible to lookups after edge N).
- Storage is flops (ENTRIES is small); no SRAM macro.

Test Plan:
- Cold start: after rst, pc_i=0x100, compressed_i=0 -> hit_o=0, pred_taken_o=0, pred_dest_o=0x104. With compressed_i=1 -> 0x102. Both counters are 0.
- Allocation and training: feedback pc=0x100 taken, target=0x80, jump=0 -> next cycle lookup 0x100 gives hit, taken, dest 0x80, ctr=2. Two not-taken feedbacks -> ctr=0, pred_dest_o=0x104, hit_o=1.
- Saturation and jumps: 5 taken feedbacks -> ctr stays 3. A jal at pc 0x200, target 0x400 -> ctr=3; lookup of 0x200 predicts 0x400. A not-taken miss at 0x300 -> no entry.
- Aliasing: with ENTRIES=16, 0x100 is allocated; taken feedback at 0x140 (same index, different tag) replaces it -> lookup 0x100 misses, 0x140 hits.
- Gating and collision: fb_valid_i=1 with fb_stall_i=1 -> no BTB or counter change. Same-cycle lookup and update of 0x100 returns old data, new data the next cycle. fb_mispred_i pulsed 3 times over 5 accepted updates -> branch_cnt_o=5, mispred_cnt_o=3.
- Flush and reset: flush_i with a concurrent update -> all lookups miss and the update is dropped. Mid-run rst with fb_valid_i=1 -> all entries invalid and both counters 0 after the edge.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// Fetch-side lookup and EX-side resolved-branch feedback bundle for the branch target predictor.
// master = fetch/EX side driving PCs and feedback, slave = predictor.
interface branch_target_predictor_if #(
    parameter int BIT_W = 32
);
    // fetch lookup
    logic [BIT_W-1:0] pc_i;
    logic             compressed_i;
    logic [BIT_W-1:0] pred_dest_o;
    logic             pred_taken_o;
    logic             hit_o;

    // resolved-branch feedback from EX
    logic             fb_valid_i;
    logic             fb_stall_i;
    logic [BIT_W-1:0] fb_pc_i;
    logic             fb_taken_i;
    logic             fb_jump_i;
    logic [BIT_W-1:0] fb_target_i;
    logic             fb_mispred_i;
    logic             flush_i;

    // statistics
    logic [31:0]      branch_cnt_o;
    logic [31:0]      mispred_cnt_o;

    modport master (
        output pc_i, compressed_i,
        output fb_valid_i, fb_stall_i, fb_pc_i, fb_taken_i, fb_jump_i,
        output fb_target_i, fb_mispred_i, flush_i,
        input  pred_dest_o, pred_taken_o, hit_o,
        input  branch_cnt_o, mispred_cnt_o
    );

    modport slave (
        input  pc_i, compressed_i,
        input  fb_valid_i, fb_stall_i, fb_pc_i, fb_taken_i, fb_jump_i,
        input  fb_target_i, fb_mispred_i, flush_i,
        output pred_dest_o, pred_taken_o, hit_o,
        output branch_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and jump flags, plus branch/mispredict statistics.
// Latency: combinational lookup; feedback updates visible one cycle after the accepting edge.
// Backpressure: none; feedback is ignored while EX is stalled, during flush and during reset.
module branch_target_predictor #(
    parameter int BIT_W   = 32,
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic clk,
    input  logic rst,
    branch_target_predictor_if.slave bus
);
    localparam int TAG_W = BIT_W - IDX_W - 1;

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] jump_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [BIT_W-1:0]   target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [31:0]        branch_cnt_q;
    logic [31:0]        mispred_cnt_q;

    // Lookup path
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [BIT_W-1:0] seq_pc;
    logic             lk_hit;
    logic             lk_taken;
    logic [BIT_W-1:0] lk_dest;

    assign lk_idx = bus.pc_i[IDX_W:1];
    assign lk_tag = bus.pc_i[BIT_W-1:IDX_W+1];
    assign seq_pc = bus.pc_i + (bus.compressed_i ? BIT_W'(2) : BIT_W'(4));

    always_comb begin
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][1]);
        lk_dest  = lk_taken ? target_q[lk_idx] : seq_pc;
    end

    assign bus.hit_o         = lk_hit;
    assign bus.pred_taken_o  = lk_taken;
    assign bus.pred_dest_o   = lk_dest;
    assign bus.branch_cnt_o  = branch_cnt_q;
    assign bus.mispred_cnt_o = mispred_cnt_q;

    // Update path
    logic [IDX_W-1:0] fb_idx;
    logic [TAG_W-1:0] fb_tag;
    logic             fb_hit;
    logic             upd;
    logic [1:0]       cur_ctr;
    logic [1:0]       ctr_inc;
    logic [1:0]       ctr_dec;

    assign fb_idx = bus.fb_pc_i[IDX_W:1];
    assign fb_tag = bus.fb_pc_i[BIT_W-1:IDX_W+1];
    assign upd    = bus.fb_valid_i && !bus.fb_stall_i;

    always_comb begin
        fb_hit  = valid_q[fb_idx] && (tag_q[fb_idx] == fb_tag);
        cur_ctr = ctr_q[fb_idx];
        ctr_inc = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
        ctr_dec = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;
    end

    // Bit 0 of either PC never selects an entry (halfword-aligned fetch).
    logic unused_pc_lsb;
    assign unused_pc_lsb = bus.pc_i[0] ^ bus.fb_pc_i[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            jump_q        <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b00;
            end
        end else begin
            if (upd) begin
                branch_cnt_q  <= branch_cnt_q + 32'd1;
                mispred_cnt_q <= mispred_cnt_q + 32'(bus.fb_mispred_i);
            end

            // Flush wins over a same-cycle update; statistics still count it.
            if (bus.flush_i) begin
                valid_q <= '0;
            end else if (upd) begin
                if (fb_hit) begin
                    if (bus.fb_jump_i) begin
                        ctr_q[fb_idx]    <= 2'b11;
                        jump_q[fb_idx]   <= 1'b1;
                        target_q[fb_idx] <= bus.fb_target_i;
                    end else if (bus.fb_taken_i) begin
                        ctr_q[fb_idx]    <= ctr_inc;
                        target_q[fb_idx] <= bus.fb_target_i;
                    end else begin
                        ctr_q[fb_idx]    <= ctr_dec;
                    end
                end else if (bus.fb_taken_i) begin
                    valid_q[fb_idx]  <= 1'b1;
                    tag_q[fb_idx]    <= fb_tag;
                    target_q[fb_idx] <= bus.fb_target_i;
                    jump_q[fb_idx]   <= bus.fb_jump_i;
                    ctr_q[fb_idx]    <= bus.fb_jump_i ? 2'b11 : 2'b10;
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed scenarios pinned by literals, then random traffic
// checked every cycle against an array-based model of the BTB and statistics.
module tb_branch_target_predictor;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_target_predictor_if #(.BIT_W(32)) bus ();

    branch_target_predictor #(.BIT_W(32), .ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model: each entry remembers the full PC that allocated it.
    bit          m_valid [N];
    logic [31:0] m_pc    [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    bit          m_jump  [N];
    logic [31:0] m_bcnt = 0;
    logic [31:0] m_mcnt = 0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    bit          lit_vld = 0;
    bit          lit_hit, lit_taken;
    logic [31:0] lit_dest;
    bit          lit_cnt_vld = 0;
    logic [31:0] lit_bcnt, lit_mcnt;
    string       lit_name;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 2) % N);
    endfunction

    function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
        return (a / (2 * N)) == (b / (2 * N));
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, input bit comp,
                                     output bit h, output bit t, output logic [31:0] d);
        int i;
        i = idx_of(pc);
        h = m_valid[i] && same_line(m_pc[i], pc);
        t = h && (m_jump[i] || m_ctr[i] >= 2);
        d = t ? m_tgt[i] : pc + (comp ? 32'd2 : 32'd4);
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Model update on every rising edge
    initial begin
        int i;
        bit acc, h;
        forever begin
            @(posedge clk);
            if (rst) begin
                for (int k = 0; k < N; k++) begin
                    m_valid[k] = 0; m_pc[k] = 0; m_tgt[k] = 0; m_ctr[k] = 0; m_jump[k] = 0;
                end
                m_bcnt = 0;
                m_mcnt = 0;
            end else begin
                acc = bus.fb_valid_i && !bus.fb_stall_i;
                if (acc) begin
                    m_bcnt = m_bcnt + 1;
                    if (bus.fb_mispred_i) m_mcnt = m_mcnt + 1;
                end
                if (bus.flush_i) begin
                    for (int k = 0; k < N; k++) m_valid[k] = 0;
                end else if (acc) begin
                    i = idx_of(bus.fb_pc_i);
                    h = m_valid[i] && same_line(m_pc[i], bus.fb_pc_i);
                    if (h) begin
                        if (bus.fb_jump_i) begin
                            m_ctr[i] = 3; m_jump[i] = 1; m_tgt[i] = bus.fb_target_i;
                        end else if (bus.fb_taken_i) begin
                            if (m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
                            m_tgt[i] = bus.fb_target_i;
                        end else if (m_ctr[i] > 0) begin
                            m_ctr[i] = m_ctr[i] - 1;
                        end
                    end else if (bus.fb_taken_i) begin
                        m_valid[i] = 1;
                        m_pc[i]    = bus.fb_pc_i;
                        m_tgt[i]   = bus.fb_target_i;
                        m_jump[i]  = bus.fb_jump_i;
                        m_ctr[i]   = bus.fb_jump_i ? 3 : 2;
                    end
                end
            end
        end
    end

    // Compare process: outputs against the model every cycle, plus literal pins when requested
    initial begin
        bit eh, et;
        logic [31:0] ed;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                m_lookup(bus.pc_i, bus.compressed_i, eh, et, ed);
                chk("hit", 32'(bus.hit_o), 32'(eh));
                chk("taken", 32'(bus.pred_taken_o), 32'(et));
                chk("dest", bus.pred_dest_o, ed);
                chk("branch_cnt", bus.branch_cnt_o, m_bcnt);
                chk("mispred_cnt", bus.mispred_cnt_o, m_mcnt);
                if (lit_vld) begin
                    chk({lit_name, "_hit"}, 32'(bus.hit_o), 32'(lit_hit));
                    chk({lit_name, "_taken"}, 32'(bus.pred_taken_o), 32'(lit_taken));
                    chk({lit_name, "_dest"}, bus.pred_dest_o, lit_dest);
                end
                if (lit_cnt_vld) begin
                    chk({lit_name, "_bcnt"}, bus.branch_cnt_o, lit_bcnt);
                    chk({lit_name, "_mcnt"}, bus.mispred_cnt_o, lit_mcnt);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fb(input logic [31:0] pc, input bit tk, input bit jp,
                      input logic [31:0] tgt, input bit mp);
        bus.fb_valid_i   = 1;
        bus.fb_pc_i      = pc;
        bus.fb_taken_i   = tk;
        bus.fb_jump_i    = jp;
        bus.fb_target_i  = tgt;
        bus.fb_mispred_i = mp;
        cyc();
        bus.fb_valid_i   = 0;
        bus.fb_mispred_i = 0;
    endtask

    task automatic look(input logic [31:0] pc, input bit comp, input bit eh, input bit et,
                        input logic [31:0] ed, input string nm);
        bus.pc_i = pc;
        bus.compressed_i = comp;
        lit_hit = eh; lit_taken = et; lit_dest = ed; lit_name = nm;
        lit_vld = 1;
        @(negedge clk);
        #1;
        lit_vld = 0;
    endtask

    task automatic cnts(input logic [31:0] b, input logic [31:0] m, input string nm);
        lit_bcnt = b; lit_mcnt = m; lit_name = nm;
        lit_cnt_vld = 1;
        @(negedge clk);
        #1;
        lit_cnt_vld = 0;
    endtask

    function automatic logic [31:0] rpc();
        if ($urandom_range(0, 15) == 0) return $urandom;
        return (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 15)) << 1);
    endfunction

    initial begin
        rst = 1;
        bus.pc_i = 32'h100; bus.compressed_i = 0;
        bus.fb_valid_i = 0; bus.fb_stall_i = 0; bus.fb_pc_i = 0; bus.fb_taken_i = 0;
        bus.fb_jump_i = 0; bus.fb_target_i = 0; bus.fb_mispred_i = 0; bus.flush_i = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk_en = 1;

        // Cold start
        look(32'h100, 0, 0, 0, 32'h104, "cold4");
        look(32'h100, 1, 0, 0, 32'h102, "cold2");
        cnts(0, 0, "cold_cnt");
        look(32'hFFFF_FFFC, 0, 0, 0, 32'h0, "wrap");

        // Allocation and training
        fb(32'h100, 1, 0, 32'h80, 0);
        look(32'h100, 0, 1, 1, 32'h80, "alloc");
        fb(32'h100, 0, 0, 32'h0, 0);
        look(32'h100, 0, 1, 0, 32'h104, "nt1");
        fb(32'h100, 0, 0, 32'h0, 0);
        look(32'h100, 0, 1, 0, 32'h104, "nt2");
        fb(32'h100, 1, 0, 32'h80, 0);
        look(32'h100, 0, 1, 0, 32'h104, "from0");

        // Saturation: five taken then two not-taken leaves ctr at 1
        repeat (5) fb(32'h100, 1, 0, 32'h80, 0);
        fb(32'h100, 0, 0, 32'h0, 0);
        look(32'h100, 0, 1, 1, 32'h80, "sat_a");
        fb(32'h100, 0, 0, 32'h0, 0);
        look(32'h100, 0, 1, 0, 32'h104, "sat_b");

        // Jump at 0x200 shares index 0 with 0x100
        fb(32'h200, 1, 1, 32'h400, 0);
        look(32'h200, 0, 1, 1, 32'h400, "jal");
        look(32'h100, 0, 0, 0, 32'h104, "jal_evict");
        fb(32'h200, 0, 0, 32'h0, 0);
        look(32'h200, 0, 1, 1, 32'h400, "jump_sticky");
        fb(32'h300, 0, 0, 32'h999, 0);
        look(32'h300, 0, 0, 0, 32'h304, "nt_miss");
        look(32'h200, 0, 1, 1, 32'h400, "nt_miss_keep");

        // Aliasing
        fb(32'h100, 1, 0, 32'h80, 0);
        fb(32'h140, 1, 0, 32'h90, 0);
        look(32'h100, 0, 0, 0, 32'h104, "alias_old");
        look(32'h140, 0, 1, 1, 32'h90, "alias_new");
        cnts(16, 0, "cnt16");

        // Stalled feedback is ignored
        bus.fb_stall_i = 1;
        fb(32'h140, 0, 0, 32'h0, 1);
        bus.fb_stall_i = 0;
        cnts(16, 0, "stall_cnt");
        look(32'h140, 0, 1, 1, 32'h90, "stall_btb");

        // Collision: same-cycle lookup sees old contents
        cyc();
        bus.fb_valid_i = 1; bus.fb_pc_i = 32'h140; bus.fb_taken_i = 1;
        bus.fb_jump_i = 0; bus.fb_target_i = 32'h300;
        look(32'h140, 0, 1, 1, 32'h90, "coll_old");
        cyc();
        bus.fb_valid_i = 0;
        look(32'h140, 0, 1, 1, 32'h300, "coll_new");

        // Flush with a concurrent update
        cyc();
        bus.flush_i = 1;
        fb(32'h204, 1, 0, 32'h500, 0);
        bus.flush_i = 0;
        look(32'h140, 0, 0, 0, 32'h144, "flush_old");
        look(32'h204, 0, 0, 0, 32'h208, "flush_drop");

        // Mid-run reset with feedback present
        fb(32'h100, 1, 0, 32'h80, 1);
        rst = 1;
        fb(32'h180, 1, 0, 32'h60, 1);
        rst = 0;
        look(32'h100, 0, 0, 0, 32'h104, "rst_clear");
        look(32'h180, 0, 0, 0, 32'h184, "rst_drop");
        cnts(0, 0, "rst_cnt");

        // Statistics: five accepted updates, three mispredicted
        fb(32'h100, 1, 0, 32'h80, 1);
        fb(32'h110, 0, 0, 32'h0, 1);
        fb(32'h120, 1, 1, 32'h40, 0);
        fb(32'h100, 0, 0, 32'h0, 1);
        fb(32'h130, 0, 0, 32'h0, 0);
        cnts(5, 3, "stats");

        // Random traffic
        repeat (4000) begin
            bus.pc_i         = rpc();
            bus.compressed_i = 1'($urandom_range(0, 1));
            bus.fb_valid_i   = ($urandom_range(0, 3) != 0);
            bus.fb_stall_i   = ($urandom_range(0, 4) == 0);
            bus.fb_pc_i      = rpc();
            bus.fb_jump_i    = ($urandom_range(0, 5) == 0);
            bus.fb_taken_i   = bus.fb_jump_i | 1'($urandom_range(0, 1));
            bus.fb_target_i  = $urandom & 32'hFFFF_FFFE;
            bus.fb_mispred_i = 1'($urandom_range(0, 1));
            bus.flush_i      = ($urandom_range(0, 63) == 0);
            rst              = ($urandom_range(0, 255) == 0);
            cyc();
        end
        rst = 0; bus.fb_valid_i = 0; bus.flush_i = 0;
        cyc();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
